// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the FSM state encoding and the stop-bit selector values used by uart_tx_fifo_rd.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_st_t;

    // Encoding of the stop_sel configuration input
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // Index of the final stop bit, counted from zero
    function automatic int last_stop_idx(input logic sel);
        return (sel == STOP_2) ? 1 : 0;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..comp and flags the last cycle of each bit.
// The divider is re-sampled only at bit boundaries, so a mid-bit change never truncates a bit.
module uart_baud_gen #(
    parameter int comp_w = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic [comp_w-1:0] comp,
    output logic              bit_end
);

    logic [comp_w-1:0] r_cnt;
    logic [comp_w-1:0] r_comp;

    assign bit_end = (r_cnt == r_comp) & ~clr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_comp <= '0;
        end else if (clr || bit_end) begin
            r_cnt  <= '0;
            r_comp <= comp;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_rd.sv
// Reads a show-ahead TX fifo and serialises each word LSB-first as an 8N1/8N2 UART frame.
// Optional parity bit after the data bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_rd
    import uart_pkg::*;
#(
    parameter int data_w = 8,
    parameter int comp_w = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tr_en,
    input  logic [comp_w-1:0] comp,
    input  logic              stop_sel,
    input  logic              par_odd,
    input  logic              fifo_emp,
    input  logic [data_w-1:0] fifo_rd,
    output logic              fifo_re,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BCW = $clog2(data_w + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(data_w - 1);

`ifdef UART_TX_PARITY_EN
    localparam uart_tx_st_t AFTER_DATA = PARITY;
    logic r_par;
`else
    localparam uart_tx_st_t AFTER_DATA = STOP;
    logic w_unused_par;
    assign w_unused_par = par_odd;
`endif

    uart_tx_st_t       r_st;
    uart_tx_st_t       w_st_next;
    logic [data_w-1:0] r_shift;
    logic [BCW-1:0]    r_bit_cnt;
    logic              r_stop_sel;
    logic              w_bit_end;
    logic              w_can_pop;
    logic              w_last_stop;
    logic              w_pop;
    logic              w_shift;
    logic              w_bcnt_inc;
    logic              w_bcnt_clr;

    uart_baud_gen #(
        .comp_w (comp_w)
    ) u_baud (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (r_st == IDLE),
        .comp    (comp),
        .bit_end (w_bit_end)
    );

    // Gated by rstn so no word is lost while reset is held
    assign w_can_pop   = rstn & tr_en & ~fifo_emp;
    assign w_last_stop = (r_bit_cnt == BCW'(last_stop_idx(r_stop_sel)));

    always_comb begin
        w_st_next  = r_st;
        w_pop      = 1'b0;
        w_shift    = 1'b0;
        w_bcnt_inc = 1'b0;
        w_bcnt_clr = 1'b0;
        tx_done    = 1'b0;
        tx         = 1'b1;
        case (r_st)
            IDLE: begin
                if (w_can_pop) begin
                    w_pop     = 1'b1;
                    w_st_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (w_bit_end) begin
                    w_bcnt_clr = 1'b1;
                    w_st_next  = DATA;
                end
            end
            DATA: begin
                tx = r_shift[0];
                if (w_bit_end) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bcnt_clr = 1'b1;
                        w_st_next  = AFTER_DATA;
                    end else begin
                        w_bcnt_inc = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = r_par;
                if (w_bit_end) begin
                    w_bcnt_clr = 1'b1;
                    w_st_next  = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        tx_done    = 1'b1;
                        w_bcnt_clr = 1'b1;
                        // Chain straight into the next frame when a word is waiting
                        if (w_can_pop) begin
                            w_pop     = 1'b1;
                            w_st_next = START;
                        end else begin
                            w_st_next = IDLE;
                        end
                    end else begin
                        w_bcnt_inc = 1'b1;
                    end
                end
            end
            default: w_st_next = IDLE;
        endcase
    end

    assign fifo_re = w_pop;
    assign busy    = (r_st != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_st       <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_sel <= STOP_1;
        end else begin
            r_st <= w_st_next;
            if (w_pop) begin
                r_shift    <= fifo_rd;
                r_stop_sel <= stop_sel;
            end else if (w_shift) begin
                r_shift    <= r_shift >> 1;
            end
            if (w_pop || w_bcnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bcnt_inc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= (^fifo_rd) ^ par_odd;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Directed bench for uart_tx_fifo_rd: frame shape, back-to-back, 2 stop bits, reset abort, tr_en gating.
// Expected frame lengths account for the extra parity bit when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_rd;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        tr_en    = 1'b0;
    logic [15:0] comp     = 16'd0;
    logic        stop_sel = 1'b0;
    logic        par_odd  = 1'b0;
    logic        fifo_emp;
    logic [7:0]  fifo_rd;
    logic        fifo_re;
    logic        tx;
    logic        busy;
    logic        tx_done;

    logic [7:0]  mem [0:15];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    int          pops   = 0;

    int          total = 0;
    int          bad   = 0;

    logic        tx_a   [0:127];
    logic        done_a [0:127];
    logic        busy_a [0:127];
    logic        re_a   [0:127];

    uart_tx_fifo_rd #(
        .data_w (8),
        .comp_w (16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .tr_en    (tr_en),
        .comp     (comp),
        .stop_sel (stop_sel),
        .par_odd  (par_odd),
        .fifo_emp (fifo_emp),
        .fifo_rd  (fifo_rd),
        .fifo_re  (fifo_re),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Show-ahead fifo model
    assign fifo_emp = (wr_ptr == rd_ptr);
    assign fifo_rd  = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_re) begin
            rd_ptr <= rd_ptr + 4'd1;
            pops   <= pops + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    // Cycle k=1 is the first cycle after the current negedge's following posedge
    task automatic cap(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tx_a[k]   = tx;
            done_a[k] = tx_done;
            busy_a[k] = busy;
            re_a[k]   = fifo_re;
            if (fifo_re) chk("re_nonempty", 32'(fifo_emp), 32'd0);
        end
    endtask

    initial begin
        int         f;
        int         p0;
        int         cnt;
        logic [7:0] w;
        logic       e;

        // Reset
        comp = 16'd3;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_re", 32'(fifo_re), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single 8'hA5 frame, 4 clks per bit
        p0 = pops;
        tr_en = 1'b1;
        push(8'hA5);
        #1;
        chk("t1_re", 32'(fifo_re), 32'd1);
        f = 4 * (10 + PB);
        cap(f + 4);
        w = 8'hA5;
        for (int b = 0; b < 9; b++) begin
            e = (b == 0) ? 1'b0 : w[b-1];
            chk($sformatf("t1_bit%0d", b), 32'(tx_a[4*b+2]), 32'(e));
        end
        chk("t1_stop", 32'(tx_a[4*(9+PB)+2]), 32'd1);
        chk("t1_done_early", 32'(done_a[f-1]), 32'd0);
        chk("t1_done", 32'(done_a[f]), 32'd1);
        chk("t1_busy_last", 32'(busy_a[f]), 32'd1);
        chk("t1_busy_after", 32'(busy_a[f+1]), 32'd0);
        chk("t1_idle_tx", 32'(tx_a[f+1]), 32'd1);
        chk("t1_pops", 32'(pops - p0), 32'd1);

        // Back-to-back 8'h00 then 8'hFF, 2 clks per bit
        comp = 16'd1;
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        #1;
        chk("t2_re", 32'(fifo_re), 32'd1);
        f = 2 * (10 + PB);
        cap(2 * f + 4);
        chk("t2_f1_bit3", 32'(tx_a[9]), 32'd0);
        chk("t2_f1_stop", 32'(tx_a[f-1]), 32'd1);
        chk("t2_chain_re", 32'(re_a[f]), 32'd1);
        chk("t2_f1_done", 32'(done_a[f]), 32'd1);
        chk("t2_f2_start", 32'(tx_a[f+1]), 32'd0);
        chk("t2_f2_bit0", 32'(tx_a[f+3]), 32'd1);
        chk("t2_f2_done_early", 32'(done_a[2*f-1]), 32'd0);
        chk("t2_f2_done", 32'(done_a[2*f]), 32'd1);
        chk("t2_f2_no_re", 32'(re_a[2*f]), 32'd0);
        chk("t2_busy_after", 32'(busy_a[2*f+1]), 32'd0);
        chk("t2_pops", 32'(pops - p0), 32'd2);

        // Two stop bits, 1 clk per bit; stop_sel dropped after the pop must not matter
        comp = 16'd0;
        stop_sel = 1'b1;
        push(8'h81);
        #1;
        chk("t3_re", 32'(fifo_re), 32'd1);
        @(posedge clk);
        #1;
        stop_sel = 1'b0;
        f = 11 + PB;
        cap(f + 3);
        chk("t3_start", 32'(tx_a[1]), 32'd0);
        chk("t3_bit0", 32'(tx_a[2]), 32'd1);
        chk("t3_bit1", 32'(tx_a[3]), 32'd0);
        chk("t3_bit7", 32'(tx_a[9]), 32'd1);
        chk("t3_stop1", 32'(tx_a[f-1]), 32'd1);
        chk("t3_stop2", 32'(tx_a[f]), 32'd1);
        chk("t3_done_early", 32'(done_a[f-1]), 32'd0);
        chk("t3_done", 32'(done_a[f]), 32'd1);
        chk("t3_busy_after", 32'(busy_a[f+1]), 32'd0);

        // Reset during data bit 3 of 8'h3C
        comp = 16'd3;
        p0 = pops;
        push(8'h3C);
        #1;
        cap(18);
        chk("t4_bit1", 32'(tx_a[10]), 32'd0);
        chk("t4_bit2", 32'(tx_a[14]), 32'd1);
        chk("t4_bit3", 32'(tx_a[18]), 32'd1);
        chk("t4_busy", 32'(busy_a[18]), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t4_rst_tx", 32'(tx), 32'd1);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_re", 32'(fifo_re), 32'd0);
        chk("t4_rst_done", 32'(tx_done), 32'd0);
        rstn = 1'b1;
        cap(30);
        cnt = 0;
        for (int k = 1; k <= 30; k++) if (tx_a[k] !== 1'b1 || busy_a[k] !== 1'b0) cnt++;
        chk("t4_quiet_after", 32'(cnt), 32'd0);
        chk("t4_pops", 32'(pops - p0), 32'd1);

        // tr_en low holds the word; then tr_en drops mid-frame
        tr_en = 1'b0;
        comp = 16'd1;
        p0 = pops;
        push(8'h5A);
        cap(20);
        cnt = 0;
        for (int k = 1; k <= 20; k++) if (re_a[k] !== 1'b0 || tx_a[k] !== 1'b1) cnt++;
        chk("t5_gated", 32'(cnt), 32'd0);
        chk("t5_gated_pops", 32'(pops - p0), 32'd0);
        tr_en = 1'b1;
        #1;
        chk("t5_re", 32'(fifo_re), 32'd1);
        f = 2 * (10 + PB);
        for (int k = 1; k <= f + 10; k++) begin
            @(negedge clk);
            tx_a[k]   = tx;
            done_a[k] = tx_done;
            busy_a[k] = busy;
            re_a[k]   = fifo_re;
            if (k == 3) push(8'h12);
            if (k == 5) tr_en = 1'b0;
        end
        chk("t5_bit0", 32'(tx_a[3]), 32'd0);
        chk("t5_bit1", 32'(tx_a[5]), 32'd1);
        chk("t5_done", 32'(done_a[f]), 32'd1);
        chk("t5_no_chain", 32'(re_a[f]), 32'd0);
        chk("t5_busy_after", 32'(busy_a[f+1]), 32'd0);
        cnt = 0;
        for (int k = f + 1; k <= f + 10; k++) if (tx_a[k] !== 1'b1 || re_a[k] !== 1'b0) cnt++;
        chk("t5_idle_after", 32'(cnt), 32'd0);
        chk("t5_pops", 32'(pops - p0), 32'd1);
        // Drain the leftover word
        tr_en = 1'b1;
        cap(f + 2);
        tr_en = 1'b0;
        chk("t5_drain", 32'(fifo_emp), 32'd1);

`ifdef UART_TX_PARITY_EN
        // Parity on 8'h07 (three ones): even -> 1, odd -> 0
        comp = 16'd0;
        tr_en = 1'b1;
        par_odd = 1'b0;
        push(8'h07);
        #1;
        cap(15);
        chk("t6_par_even", 32'(tx_a[10]), 32'd1);
        chk("t6_stop_even", 32'(tx_a[11]), 32'd1);
        chk("t6_done_even", 32'(done_a[11]), 32'd1);
        par_odd = 1'b1;
        push(8'h07);
        #1;
        cap(15);
        chk("t6_par_odd", 32'(tx_a[10]), 32'd0);
        chk("t6_done_odd", 32'(done_a[11]), 32'd1);
        tr_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
